// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle between a PRBS source/monitor and prbs_checker.
// The master drives the received stream; the slave (the checker) reports lock and errors.
interface prbs_checker_if;
  logic       en;
  logic       data_in;
  logic       err_clr;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  modport master (
    output en, data_in, err_clr,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  en, data_in, err_clr,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^4+x^3+1 PRBS: hunts for lock on the received stream,
// then flywheels the local LFSR and flags/counts every bit that departs from the prediction.
module prbs_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input logic           clk,
  input logic           rst,
  prbs_checker_if.slave bus
);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

  state_e     state_q, state_d;
  logic [3:0] c_q, c_d;
  logic [2:0] fill_q, fill_d;
  logic [3:0] match_q, match_d;
  logic [3:0] consec_q, consec_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;

  logic pred;
  logic miss;
  logic count_err;

  assign pred = c_q[3] ^ c_q[2];
  assign miss = (bus.data_in != pred);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latch).
    state_d     = state_q;
    c_d         = c_q;
    fill_d      = fill_q;
    match_d     = match_q;
    consec_d    = consec_q;
    err_pulse_d = 1'b0;
    count_err   = 1'b0;

    if (bus.en) begin
      case (state_q)
        ST_HUNT: begin
          c_d = {c_q[2:0], bus.data_in};
          if (fill_q != 3'd4) begin
            fill_d = fill_q + 3'd1;
          end else if (!miss && (c_q != 4'd0)) begin
            // An all-zero register predicts zero forever, so it must never count towards lock.
            if (match_q == 4'(LOCK_CNT - 1)) begin
              state_d  = ST_LOCKED;
              match_d  = 4'd0;
              consec_d = 4'd0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d = 4'd0;
          end
        end

        ST_LOCKED: begin
          // Flywheel on our own prediction so isolated line errors cannot knock us out of phase.
          c_d = {c_q[2:0], pred};
          if (miss) begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            if (consec_q == 4'(LOSS_CNT - 1)) begin
              state_d  = ST_HUNT;
              fill_d   = 3'd0;
              match_d  = 4'd0;
              consec_d = 4'd0;
            end else begin
              consec_d = consec_q + 4'd1;
            end
          end else begin
            consec_d = 4'd0;
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    err_count_d = err_count_q;
    if (bus.err_clr) begin
      err_count_d = 8'd0;
    end else if (count_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      c_q         <= 4'd0;
      fill_q      <= 3'd0;
      match_q     <= 4'd0;
      consec_q    <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      consec_q    <= consec_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: dut_a uses default parameters, dut_b uses LOSS_CNT = 15
// for the saturation run; both see identical stimulus.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_if if_a ();
  prbs_checker_if if_b ();

  prbs_checker dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  prbs_checker #(.LOCK_CNT(8), .LOSS_CNT(15)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // Generator output seeded 0001, one period.
  bit stream [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int idx = 0;

  int total = 0;
  int bad   = 0;
  int pulses;
  int ever_locked;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic d, input logic clr);
    @(negedge clk);
    if_a.en = e; if_a.data_in = d; if_a.err_clr = clr;
    if_b.en = e; if_b.data_in = d; if_b.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Next generator bit, optionally inverted; the generator phase always advances.
  task automatic send_bit(input logic inv, input logic clr = 1'b0);
    drive(1'b1, stream[idx] ^ inv, clr);
    idx = (idx + 1) % 15;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic quick_reset();
    @(negedge clk);
    rst = 1'b1;
    if_a.en = 1'b0; if_b.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idx = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_a.en = 1'b0; if_a.data_in = 1'b0; if_a.err_clr = 1'b0;
    if_b.en = 1'b0; if_b.data_in = 1'b0; if_b.err_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_locked", if_a.locked, 0);
    check("reset_pulse", if_a.err_pulse, 0);
    check("reset_count", if_a.err_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean lock: locked rises on the 12th bit.
    idx = 0;
    for (int k = 1; k <= 11; k++) send_bit(1'b0);
    check("prelock_bit11", if_a.locked, 0);
    send_bit(1'b0);
    check("lock_bit12", if_a.locked, 1);
    pulses = 0;
    for (int k = 13; k <= 100; k++) begin
      send_bit(1'b0);
      if (if_a.err_pulse) pulses++;
    end
    check("clean_pulses", pulses, 0);
    check("clean_count", if_a.err_count, 0);
    check("clean_locked", if_a.locked, 1);

    // Single flip at bit 30.
    quick_reset();
    for (int k = 1; k <= 29; k++) send_bit(1'b0);
    send_bit(1'b1);
    check("flip_pulse", if_a.err_pulse, 1);
    check("flip_count", if_a.err_count, 1);
    check("flip_locked", if_a.locked, 1);
    send_bit(1'b0);
    check("flip_pulse_drop", if_a.err_pulse, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      send_bit(1'b0);
      if (if_a.err_pulse) pulses++;
    end
    check("flip_no_more", pulses, 0);
    check("flip_count_hold", if_a.err_count, 1);

    // Loss and relock.
    send_bit(1'b0, 1'b1);
    check("clr_count", if_a.err_count, 0);
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    check("loss_bit3_locked", if_a.locked, 1);
    send_bit(1'b1);
    check("loss_bit4_locked", if_a.locked, 0);
    check("loss_count", if_a.err_count, 4);
    check("loss_pulse", if_a.err_pulse, 1);
    for (int k = 0; k < 11; k++) send_bit(1'b0);
    check("relock_bit11", if_a.locked, 0);
    send_bit(1'b0);
    check("relock_bit12", if_a.locked, 1);

    // Asynchronous reset mid-cycle while locked with a non-zero count.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_locked", if_a.locked, 0);
    check("async_count", if_a.err_count, 0);
    check("async_pulse", if_a.err_pulse, 0);
    for (int k = 0; k < 3; k++) begin
      drive(k[0], ~k[0], 1'b0);
      check("rst_hold", int'(if_a.locked) + int'(if_a.err_pulse) + int'(if_a.err_count), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    if_a.en = 1'b0; if_b.en = 1'b0;

    // Stuck-at-0 then stuck-at-1 never locks.
    ever_locked = 0;
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (if_a.locked) ever_locked++;
    end
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (if_a.locked) ever_locked++;
    end
    check("stuck_locked", ever_locked, 0);
    check("stuck_count", if_a.err_count, 0);

    // Gapped en: one enabled cycle in three.
    quick_reset();
    for (int k = 1; k <= 11; k++) begin
      send_bit(1'b0);
      idle(2);
    end
    check("gap_prelock", if_a.locked, 0);
    send_bit(1'b0);
    check("gap_lock_a", if_a.locked, 1);
    check("gap_lock_b", if_b.locked, 1);
    idle(2);

    // Inverted bursts drop lock each round; count saturates on dut_b (15 errors per round).
    for (int r = 1; r <= 18; r++) begin
      for (int k = 0; k < 15; k++) send_bit(1'b1);
      if (r == 1) check("sat_b_unlock", if_b.locked, 0);
      for (int k = 0; k < 12; k++) send_bit(1'b0);
      if (r == 16) check("sat_b_240", if_b.err_count, 240);
      if (r == 17) check("sat_b_255", if_b.err_count, 255);
    end
    check("sat_b_hold", if_b.err_count, 255);
    check("sat_b_relocked", if_b.locked, 1);
    check("sat_a_count", if_a.err_count, 72);

    // err_clr together with an error.
    send_bit(1'b1, 1'b1);
    check("clr_err_count", if_b.err_count, 0);
    check("clr_err_pulse", if_b.err_pulse, 1);
    check("clr_err_locked", if_b.locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receiver for the 4-bit pseudo-random sequence generator: consumes one bit per enabled cycle, self-synchronises a local copy of the x^4+x^3+1 LFSR to the incoming stream, then flags and counts every bit that departs from the predicted sequence. Sits at the far end of a serial link or loopback path, alongside the lab's generator, as its built-in self-test partner. Period-15 sequence, any non-zero phase.

## Interface
- LOCK_CNT, default 8: consecutive correct predictions required in HUNT before declaring lock (1..15).
- LOSS_CNT, default 4: consecutive mispredictions in LOCKED before dropping lock (1..15).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  bit-valid strobe; data_in sampled only when high.
- data_in  in  1  received serial bit.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle strobe per mispredicted bit while LOCKED.
- err_count  out  8  saturating count of mispredicted bits while LOCKED.

## Operation
- Local register c[3:0]; prediction p = c[3] ^ c[2] (matches generator feedback; serial bit = generator's new c[0]).
- State HUNT (reset state):
  - Each en cycle: c <= {c[2:0], data_in}.
  - fill counter 0..4 increments until 4; no comparison while fill < 4.
  - fill == 4: if data_in == p and c != 0 then match += 1, else match <= 0.
  - match reaching LOCK_CNT -> LOCKED on that edge; consec-error counter cleared.
  - c == 0 never counts as a match: stuck-at-0 line never locks; stuck-at-1 mispredicts from c = 1111 and never locks.
- State LOCKED:
  - Flywheel: c <= {c[2:0], p}; data_in never loaded, so single errors do not desynchronise.
  - data_in != p: err_pulse <= 1, err_count += 1 (saturates at 255), consec += 1.
  - data_in == p: consec <= 0.
  - consec reaching LOSS_CNT -> HUNT on that edge; fill, match, consec <= 0. The LOSS_CNT-th error is still counted and pulsed.
- err_clr: err_count <= 0 next edge; takes priority over a simultaneous error (count 0, err_pulse still 1). Independent of en and state.
- en low: all state holds, err_pulse <= 0.
- Reset values: locked 0, err_pulse 0, err_count 0, c 0000, fill 0, match 0, consec 0, state HUNT. Reset mid-operation returns to this immediately, without waiting for a clock edge.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- err_pulse valid the cycle after the edge sampling the erroneous bit; high exactly one cycle per error.
- Lock latency on a clean stream: locked rises at the edge sampling the (4 + LOCK_CNT)-th enabled bit (12th by default). The next enabled bit is the first one checked in LOCKED.
- Loss latency: locked falls at the edge sampling the LOSS_CNT-th consecutive bad bit.
- Throughput: one bit per cycle; en may be held high continuously or gapped arbitrarily.

## Test plan
- Reset: assert rst mid-cycle with en and data toggling -> locked, err_pulse and err_count read 0 immediately and stay 0 while rst is high.
- Clean lock: generator seeded 0001, stream 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeating, en held high -> locked rises at the 12th bit edge; err_count stays 0 over 100 bits.
- Single flip: invert bit 30 after lock -> err_pulse high for one cycle, err_count = 1, locked stays 1, bits 31 onward produce no further error.
- Loss and relock: after lock, invert 4 consecutive bits -> err_count = 4, locked falls on the 4th edge. Then resume the correct stream -> locked rises again 12 enabled bits later.
- Stuck inputs: data_in held 0 for 60 en cycles, then held 1 for 60 en cycles -> locked never rises, err_count stays 0.
- Gapped en and saturation: en high one cycle in three with a clean stream -> lock at the 12th enabled bit. Then drive an inverted stream with LOSS_CNT = 15 and relock repeatedly until more than 255 errors -> err_count holds at 255. Pulse err_clr together with an error -> err_count = 0 and err_pulse = 1.
